divider32by16_pipelined: RTL and testbench

Fully pipelined restoring divider that is the inverse of the 16-bit pipelined multiplier. It divides a 2·WIDTH-bit dividend by a WIDTH-bit divisor, producing a WIDTH-bit quotient and remainder. One radix-2 step per stage; it accepts a new operand pair every clock and has fixed latency. Products from the multiplier feed it directly, so the pair serves as the round-trip check for the multiply datapath.

---
 rtl/divider32by16_pipelined.sv | 78 +++++++
 tb/tb_divider32by16_pipelined.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/divider32by16_pipelined.sv
// Pipelined restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor, one radix-2 step per stage.
// Latency WIDTH+1 edges from issue to registered outputs; no backpressure, accepts one pair per clock.
module divider32by16_pipelined #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               ovf
);

  // Stage k register holds the operand after k restoring steps (stage 0 = captured input).
  logic             stg_vld [WIDTH];
  logic [WIDTH-1:0] stg_r   [WIDTH];
  logic [WIDTH-1:0] stg_lo  [WIDTH];
  logic [WIDTH-1:0] stg_dv  [WIDTH];
  logic [WIDTH-1:0] stg_q   [WIDTH];
  logic             stg_ovf [WIDTH];

  logic [WIDTH:0]   step_t    [WIDTH];
  logic [WIDTH:0]   step_diff [WIDTH];
  logic             step_ge   [WIDTH];
  logic [WIDTH-1:0] step_r    [WIDTH];
  logic [WIDTH-1:0] step_q    [WIDTH];

  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      step_t[k]    = {stg_r[k], stg_lo[k][WIDTH-1]};
      step_diff[k] = step_t[k] - {1'b0, stg_dv[k]};
      step_ge[k]   = (step_t[k] >= {1'b0, stg_dv[k]});
      step_r[k]    = step_ge[k] ? step_diff[k][WIDTH-1:0] : step_t[k][WIDTH-1:0];
      step_q[k]    = {stg_q[k][WIDTH-2:0], step_ge[k]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < WIDTH; k++) begin
        stg_vld[k] <= 1'b0;
        stg_r[k]   <= '0;
        stg_lo[k]  <= '0;
        stg_dv[k]  <= '0;
        stg_q[k]   <= '0;
        stg_ovf[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
    end else begin
      // A high half >= divisor means the quotient needs more than WIDTH bits (covers divisor == 0).
      stg_vld[0] <= in_valid;
      stg_r[0]   <= dividend[2*WIDTH-1:WIDTH];
      stg_lo[0]  <= dividend[WIDTH-1:0];
      stg_dv[0]  <= divisor;
      stg_q[0]   <= '0;
      stg_ovf[0] <= (dividend[2*WIDTH-1:WIDTH] >= divisor);
      for (int k = 1; k < WIDTH; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg_r[k]   <= step_r[k-1];
        stg_lo[k]  <= stg_lo[k-1] << 1;
        stg_dv[k]  <= stg_dv[k-1];
        stg_q[k]   <= step_q[k-1];
        stg_ovf[k] <= stg_ovf[k-1];
      end
      out_valid <= stg_vld[WIDTH-1];
      quotient  <= stg_ovf[WIDTH-1] ? '1 : step_q[WIDTH-1];
      remainder <= stg_ovf[WIDTH-1] ? '0 : step_r[WIDTH-1];
      ovf       <= stg_ovf[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_divider32by16_pipelined.sv
// Scoreboard bench for divider32by16_pipelined: directed vectors, reset mid-flight, random pairs.
module tb_divider32by16_pipelined;

  localparam int W   = 16;
  localparam int LAT = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          out_valid;
  logic [W-1:0]  quotient, remainder;
  logic          ovf;

  divider32by16_pipelined #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .quotient(quotient), .remainder(remainder), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned    issue_edge;
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           o;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest outstanding issue, exactly LAT edges later.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 64'(cyc - e.issue_edge), 64'(LAT));
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("ovf", 64'(ovf), 64'(e.o));
        if (!e.o)
          chk("identity", 64'(quotient) * 64'(e.dvs) + 64'(remainder), 64'(e.dvd));
      end
    end
  end

  // All drive tasks start and end just after a rising edge.
  task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic o);
    exp_t e;
    in_valid = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    e.issue_edge = cyc + 1;
    e.dvd = dvd; e.dvs = dvs; e.q = q; e.r = r; e.o = o;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h0000;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue_model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
    logic [W-1:0] hi;
    hi = dvd[2*W-1:W];
    if (hi >= dvs) issue(dvd, dvs, 16'hFFFF, 16'h0000, 1'b1);
    else           issue(dvd, dvs, W'(dvd / 32'(dvs)), W'(dvd % 32'(dvs)), 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // Single op
    issue(32'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    idle(20);

    // Back-to-back multiplier round trip
    issue(32'd2, 16'd2, 16'd1, 16'd0, 1'b0);
    issue(32'd6, 16'd3, 16'd2, 16'd0, 1'b0);
    issue(32'd12, 16'd4, 16'd3, 16'd0, 1'b0);
    issue(32'd20, 16'd5, 16'd4, 16'd0, 1'b0);
    issue(32'd30, 16'd6, 16'd5, 16'd0, 1'b0);
    idle(20);

    // Overflow, divide-by-zero, largest legal
    issue(32'h0001_0000, 16'd1, 16'hFFFF, 16'h0000, 1'b1);
    issue(32'd1234, 16'd0, 16'hFFFF, 16'h0000, 1'b1);
    issue(32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
    issue(32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
    idle(20);

    // Bubbles: issue, idle, issue, issue
    issue(32'd1000, 16'd9, 16'd111, 16'd1, 1'b0);
    idle(1);
    issue(32'h0012_3456, 16'h0100, 16'h1234, 16'h0056, 1'b0);
    issue(32'd65535, 16'd256, 16'd255, 16'd255, 1'b0);
    idle(20);

    // Reset mid-flight: 8 ops in flight, async reset, none may emerge
    for (int i = 0; i < 8; i++) issue(32'd77 + 32'(i), 16'd3, 16'd25, 16'd2, 1'b0);
    idle(2);
    #2;
    reset = 1'b0;
    sb.delete();
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_quotient", 64'(quotient), 64'd0);
    chk("arst_remainder", 64'(remainder), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    issue(32'd50, 16'd8, 16'd6, 16'd2, 1'b0);
    idle(20);

    // Random pairs with random in_valid
    for (int i = 0; i < 10000; i++) begin
      logic [2*W-1:0] dvd;
      logic [W-1:0]   dvs;
      dvd = $urandom;
      dvs = W'($urandom);
      if ($urandom_range(0, 3) != 0 && dvs != 0) dvd[2*W-1:W] = dvd[2*W-1:W] % dvs;
      if ($urandom_range(0, 7) == 0) dvs = W'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) issue_model(dvd, dvs);
      else idle(1);
    end
    idle(LAT + 4);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
